mac_accumulator: RTL and testbench



---
 rtl/mac_accumulator.sv | 92 +++++++++
 tb/tb_mac_accumulator.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_accumulator.sv
// Iterative shift-add multiply-accumulate stage: one multiplier bit per cycle,
// then a single add of the product into a wide running sum with sticky overflow.
module mac_accumulator #(
  parameter int WA   = 16,
  parameter int WB   = 16,
  parameter int WACC = 34   // must be at least WA+WB
) (
  input  logic            C,
  input  logic            Rn,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [WA-1:0]   A,
  input  logic [WB-1:0]   B,
  input  logic            clr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [WACC-1:0] ACC,
  output logic            ovf
);

  localparam int WP = WA + WB;
  localparam int IW = (WB > 1) ? $clog2(WB) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_MULT  = 2'd1;
  localparam logic [1:0] S_ACCUM = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]    state;
  logic [WA-1:0] a_reg;
  logic [WB-1:0] b_reg;
  logic          clr_reg;
  logic [WP-1:0] p;
  logic [IW-1:0] i;

  logic [WP-1:0]   addend;
  logic [WACC-1:0] base;
  logic [WACC:0]   sum;

  // NOTE: every combinational output gets a value on every path, so no latch is inferred.
  always_comb begin
    addend = WP'(a_reg) << i;
    base   = clr_reg ? '0 : ACC;
    sum    = {1'b0, base} + (WACC+1)'(p);
  end

  // NOTE: async active-low reset clears every register, including operand copies.
  always_ff @(posedge C or negedge Rn) begin
    if (!Rn) begin
      state   <= S_IDLE;
      a_reg   <= '0;
      b_reg   <= '0;
      clr_reg <= 1'b0;
      p       <= '0;
      i       <= '0;
      ACC     <= '0;
      ovf     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_reg   <= A;
            b_reg   <= B;
            clr_reg <= clr;
            p       <= '0;
            i       <= '0;
            state   <= S_MULT;
          end
        end
        S_MULT: begin
          if (b_reg[i]) p <= p + addend;
          i <= i + IW'(1);
          // Fixed latency: no early exit on zero or leading-zero multipliers.
          if (i == IW'(WB - 1)) state <= S_ACCUM;
        end
        S_ACCUM: begin
          ACC   <= sum[WACC-1:0];
          ovf   <= clr_reg ? 1'b0 : (ovf | sum[WACC]);
          state <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);

endmodule

// File: tb/tb_mac_accumulator.sv
// Scoreboard bench for mac_accumulator: directed boundary cases plus randomized
// operand pairs checked against an arithmetic accumulate model.
module tb_mac_accumulator;

  localparam int WA   = 16;
  localparam int WB   = 16;
  localparam int WACC = 34;
  localparam int LAT  = WB + 1;

  logic            C = 1'b0;
  logic            Rn = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [WA-1:0]   A = '0;
  logic [WB-1:0]   B = '0;
  logic            clr = 1'b0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [WACC-1:0] ACC;
  logic            ovf;

  mac_accumulator #(.WA(WA), .WB(WB), .WACC(WACC)) dut (
    .C(C), .Rn(Rn), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .clr(clr), .out_valid(out_valid), .out_ready(out_ready),
    .ACC(ACC), .ovf(ovf)
  );

  always #5 C = ~C;

  typedef struct {
    logic [WACC-1:0] acc;
    logic            ovf;
    int              accept_cyc;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic prev_ov = 1'b0;

  logic [WACC-1:0] m_acc = '0;
  logic            m_ovf = 1'b0;

  always @(posedge C) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: the sum is plain integer arithmetic, wrapped to WACC bits.
  task automatic model_update(input logic [WA-1:0] a, input logic [WB-1:0] b, input logic c);
    logic [63:0] full;
    full  = (c ? 64'd0 : 64'(m_acc)) + 64'(a) * 64'(b);
    m_ovf = c ? 1'b0 : (m_ovf | (full >= (64'd1 << WACC)));
    m_acc = full[WACC-1:0];
  endtask

  task automatic push_expect();
    exp_t e;
    e.acc = m_acc;
    e.ovf = m_ovf;
    e.accept_cyc = cyc;
    sb.push_back(e);
  endtask

  // Presents a pair and returns at the negedge after the accepting edge.
  task automatic send(input logic [WA-1:0] a, input logic [WB-1:0] b, input logic c);
    int n = 0;
    @(negedge C);
    A = a; B = b; clr = c; in_valid = 1'b1;
    while (!in_ready && n < 200) begin
      @(negedge C);
      n++;
    end
    if (!in_ready) check("accept_timeout", 64'(in_ready), 64'd1);
    @(posedge C);
    #1;
    model_update(a, b, c);
    push_expect();
    @(negedge C);
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!out_valid && n < 100) begin
      @(negedge C);
      n++;
    end
    check("done_timeout", 64'(out_valid), 64'd1);
  endtask

  // Monitor: one scoreboard entry per rising out_valid.
  always @(negedge C) begin
    if (Rn && out_valid && !prev_ov) begin
      if (sb.size() == 0) begin
        check("unexpected_out", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("acc", 64'(ACC), 64'(e.acc));
        check("ovf", 64'(ovf), 64'(e.ovf));
        check("latency", 64'(cyc - e.accept_cyc), 64'(LAT));
      end
    end
    prev_ov <= out_valid;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    n_fail++;
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

  initial begin
    logic [WA-1:0] ra;
    logic [WB-1:0] rb;
    logic          rc;
    int            n;

    repeat (3) @(negedge C);
    check("rst_acc", 64'(ACC), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    Rn = 1'b1;

    // Basic product, then accumulate without clear, then zero product.
    send(16'd3, 16'd5, 1'b1);
    check("busy_in_ready", 64'(in_ready), 64'd0);
    wait_done();
    check("acc_15", 64'(ACC), 64'd15);
    send(16'd7, 16'd9, 1'b0);
    wait_done();
    check("acc_78", 64'(ACC), 64'd78);
    send(16'hFFFF, 16'd0, 1'b0);
    wait_done();
    check("acc_78_b0", 64'(ACC), 64'd78);

    // Backpressure holds the result and blocks new input.
    @(negedge C);
    out_ready = 1'b0;
    send(16'd2, 16'd2, 1'b1);
    wait_done();
    repeat (10) begin
      @(negedge C);
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_acc", 64'(ACC), 64'd4);
      check("bp_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge C);
    #1;
    check("bp_release_in_ready", 64'(in_ready), 64'd1);

    // Overflow: four maximal products fit, the fifth carries out.
    send(16'hFFFF, 16'hFFFF, 1'b1);
    wait_done();
    repeat (3) begin
      send(16'hFFFF, 16'hFFFF, 1'b0);
      wait_done();
    end
    check("ovf4_acc", 64'(ACC), 64'h3_FFF8_0004);
    check("ovf4_flag", 64'(ovf), 64'd0);
    send(16'hFFFF, 16'hFFFF, 1'b0);
    wait_done();
    check("ovf5_acc", 64'(ACC), 64'h0_FFF6_0005);
    check("ovf5_flag", 64'(ovf), 64'd1);
    send(16'hFFFF, 16'hFFFF, 1'b0);
    wait_done();
    check("ovf_sticky", 64'(ovf), 64'd1);
    send(16'd1, 16'd1, 1'b1);
    wait_done();
    check("clr_acc", 64'(ACC), 64'd1);
    check("clr_ovf", 64'(ovf), 64'd0);

    // Async reset in the middle of a multiply.
    send(16'h1234, 16'h5678, 1'b0);
    repeat (7) @(negedge C);
    @(posedge C);
    #2;
    Rn = 1'b0;
    #1;
    check("arst_acc", 64'(ACC), 64'd0);
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_in_ready", 64'(in_ready), 64'd1);
    sb.delete();
    m_acc = '0;
    m_ovf = 1'b0;
    @(negedge C);
    Rn = 1'b1;
    send(16'd2, 16'd3, 1'b1);
    wait_done();
    check("arst_after", 64'(ACC), 64'd6);

    // in_valid held high with changing operands while busy.
    @(negedge C);
    A = 16'h1234; B = 16'h0010; clr = 1'b1; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge C);
      n++;
    end
    @(posedge C);
    #1;
    model_update(16'h1234, 16'h0010, 1'b1);
    push_expect();
    repeat (6) begin
      @(negedge C);
      A = WA'($urandom); B = WB'($urandom); clr = 1'($urandom);
    end
    in_valid = 1'b0;
    wait_done();
    check("gating_acc", 64'(ACC), 64'h12340);

    // Randomized pairs, with occasional zero/maximal operands and stalls.
    repeat (30) begin
      ra = WA'($urandom);
      rb = WB'($urandom);
      case ($urandom_range(0, 7))
        0: ra = '0;
        1: rb = '0;
        2: begin ra = '1; rb = '1; end
        default: ;
      endcase
      rc = ($urandom_range(0, 4) == 0);
      send(ra, rb, rc);
      wait_done();
      if ($urandom_range(0, 2) == 0) begin
        out_ready = 1'b0;
        repeat ($urandom_range(1, 4)) @(negedge C);
        out_ready = 1'b1;
      end
      repeat ($urandom_range(0, 3)) @(negedge C);
    end

    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge C);
      n++;
    end
    check("sb_drained", 64'(sb.size()), 64'd0);
    repeat (3) @(negedge C);
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
